// File: rtl/ellipse_pkg.sv
// Shared constants for the multi-slot ellipse overlay: register map, ctrl bits,
// pipeline latency and product-width helpers.
package ellipse_pkg;

  localparam int unsigned REG_CX     = 0;
  localparam int unsigned REG_CY     = 1;
  localparam int unsigned REG_RX     = 2;
  localparam int unsigned REG_RY     = 3;
  localparam int unsigned REG_COLOUR = 4;
  localparam int unsigned REG_CTRL   = 5;
  localparam int unsigned NUM_REGS   = 6;

  localparam int unsigned CTRL_EN    = 0;
  localparam int unsigned CTRL_BLEND = 1;

  localparam int unsigned LATENCY    = 4;

  // Guard bit on a+b so the sum of two full-width products cannot wrap.
  localparam int unsigned SUM_GUARD_W = 1;

  function automatic int unsigned sq_w(input int unsigned w);
    return 2 * w;
  endfunction

  function automatic int unsigned r2p_w(input int unsigned xw, input int unsigned yw);
    return 2 * xw + 2 * yw;
  endfunction

endpackage

// File: rtl/ellipse_point_test.sv
// Stages S2..S4 of the inside-ellipse test for one slot; every stage loads only
// behind a valid pixel so the last result holds across bubbles.
module ellipse_point_test
  import ellipse_pkg::*;
#(
  parameter int X_W    = 11,
  parameter int Y_W    = 12,
  parameter int DATA_W = 32
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          vld_p1,
  input  logic [X_W-1:0]                dx_p1,
  input  logic [Y_W-1:0]                dy_p1,
  input  logic [sq_w(X_W)-1:0]          rx2_p1,
  input  logic [sq_w(Y_W)-1:0]          ry2_p1,
  input  logic [r2p_w(X_W, Y_W)-1:0]    r2p_p1,
  input  logic                          armed_p1,
  input  logic                          blend_p1,
  input  logic [DATA_W-1:0]             colour_p1,
  output logic                          inside_p4,
  output logic                          blend_p4,
  output logic [DATA_W-1:0]             colour_p4
);

  localparam int RX2_W = sq_w(X_W);
  localparam int RY2_W = sq_w(Y_W);
  localparam int R2P_W = r2p_w(X_W, Y_W);
  localparam int SUM_W = R2P_W + SUM_GUARD_W;

  logic                vld_p2, vld_p3;
  logic [RX2_W-1:0]    dx2_p2, rx2_p2;
  logic [RY2_W-1:0]    dy2_p2, ry2_p2;
  logic [R2P_W-1:0]    r2p_p2, r2p_p3;
  logic                armed_p2, armed_p3, blend_p2, blend_p3;
  logic [DATA_W-1:0]   colour_p2, colour_p3;
  logic [SUM_W-1:0]    sum_p3;
  logic [R2P_W-1:0]    a_p2, b_p2;

  always_comb begin
    a_p2 = R2P_W'(dx2_p2) * R2P_W'(ry2_p2);
    b_p2 = R2P_W'(dy2_p2) * R2P_W'(rx2_p2);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p2 <= 1'b0; vld_p3 <= 1'b0;
      dx2_p2 <= '0; dy2_p2 <= '0; rx2_p2 <= '0; ry2_p2 <= '0; r2p_p2 <= '0;
      armed_p2 <= 1'b0; blend_p2 <= 1'b0; colour_p2 <= '0;
      sum_p3 <= '0; r2p_p3 <= '0; armed_p3 <= 1'b0; blend_p3 <= 1'b0; colour_p3 <= '0;
      inside_p4 <= 1'b0; blend_p4 <= 1'b0; colour_p4 <= '0;
    end else begin
      vld_p2 <= vld_p1;
      vld_p3 <= vld_p2;
      // S2: squared distances
      if (vld_p1) begin
        dx2_p2    <= RX2_W'(dx_p1) * RX2_W'(dx_p1);
        dy2_p2    <= RY2_W'(dy_p1) * RY2_W'(dy_p1);
        rx2_p2    <= rx2_p1;
        ry2_p2    <= ry2_p1;
        r2p_p2    <= r2p_p1;
        armed_p2  <= armed_p1;
        blend_p2  <= blend_p1;
        colour_p2 <= colour_p1;
      end
      // S3: cross-multiplied ellipse equation
      if (vld_p2) begin
        sum_p3    <= SUM_W'(a_p2) + SUM_W'(b_p2);
        r2p_p3    <= r2p_p2;
        armed_p3  <= armed_p2;
        blend_p3  <= blend_p2;
        colour_p3 <= colour_p2;
      end
      // S4: inside decision, boundary counts as inside
      if (vld_p3) begin
        inside_p4 <= armed_p3 && (sum_p3 <= SUM_W'(r2p_p3));
        blend_p4  <= blend_p3;
        colour_p4 <= colour_p3;
      end
    end
  end

endmodule

// File: rtl/ellipse_renderer_multi.sv
// In-line pixel stage overlaying up to NUM_SHAPES filled ellipses; holds the slot
// register file, derived squares, stage S1, priority resolution and blending.
module ellipse_renderer_multi
  import ellipse_pkg::*;
#(
  parameter int X_W        = 11,
  parameter int Y_W        = 12,
  parameter int DATA_W     = 32,
  parameter int NUM_SHAPES = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              program_in,
  input  logic              valid_in,
  input  logic [X_W-1:0]    x,
  input  logic [Y_W-1:0]    y,
  input  logic [DATA_W-1:0] data_in,
  output logic              valid_out,
  output logic [X_W-1:0]    x_out,
  output logic [Y_W-1:0]    y_out,
  output logic [DATA_W-1:0] data_out
);

  localparam int RX2_W = sq_w(X_W);
  localparam int RY2_W = sq_w(Y_W);
  localparam int R2P_W = r2p_w(X_W, Y_W);

  logic [X_W-1:0]    cx [NUM_SHAPES];
  logic [X_W-1:0]    rx [NUM_SHAPES];
  logic [Y_W-1:0]    cy [NUM_SHAPES];
  logic [Y_W-1:0]    ry [NUM_SHAPES];
  logic [DATA_W-1:0] colour [NUM_SHAPES];
  logic [1:0]        ctrl [NUM_SHAPES];
  logic [RX2_W-1:0]  rx2 [NUM_SHAPES];
  logic [RY2_W-1:0]  ry2 [NUM_SHAPES];
  logic [R2P_W-1:0]  r2p [NUM_SHAPES];

  logic wr_hit, accept;
  assign wr_hit = program_in && (32'(x) < NUM_SHAPES) && (32'(y) < NUM_REGS);
  assign accept = valid_in && !program_in;

  // Register file; squares lag a radius write by one cycle, r2p by two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_SHAPES; i++) begin
        cx[i] <= '0; cy[i] <= '0; rx[i] <= '0; ry[i] <= '0;
        colour[i] <= '0; ctrl[i] <= '0;
        rx2[i] <= '0; ry2[i] <= '0; r2p[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_SHAPES; i++) begin
        if (wr_hit && (32'(x) == i)) begin
          case (32'(y))
            REG_CX:     cx[i]     <= data_in[X_W-1:0];
            REG_CY:     cy[i]     <= data_in[Y_W-1:0];
            REG_RX:     rx[i]     <= data_in[X_W-1:0];
            REG_RY:     ry[i]     <= data_in[Y_W-1:0];
            REG_COLOUR: colour[i] <= data_in;
            REG_CTRL:   ctrl[i]   <= data_in[1:0];
            default: ;
          endcase
        end
        rx2[i] <= RX2_W'(rx[i]) * RX2_W'(rx[i]);
        ry2[i] <= RY2_W'(ry[i]) * RY2_W'(ry[i]);
        r2p[i] <= R2P_W'(rx2[i]) * R2P_W'(ry2[i]);
      end
    end
  end

  logic              vld_p1, vld_p2, vld_p3, vld_p4;
  logic [X_W-1:0]    x_p1, x_p2, x_p3, x_p4;
  logic [Y_W-1:0]    y_p1, y_p2, y_p3, y_p4;
  logic [DATA_W-1:0] d_p1, d_p2, d_p3, d_p4;
  logic [X_W-1:0]    dx_p1 [NUM_SHAPES];
  logic [Y_W-1:0]    dy_p1 [NUM_SHAPES];
  logic [RX2_W-1:0]  rx2_p1 [NUM_SHAPES];
  logic [RY2_W-1:0]  ry2_p1 [NUM_SHAPES];
  logic [R2P_W-1:0]  r2p_p1 [NUM_SHAPES];
  logic [DATA_W-1:0] colour_p1 [NUM_SHAPES];
  logic [NUM_SHAPES-1:0] armed_p1, blend_p1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0; vld_p2 <= 1'b0; vld_p3 <= 1'b0; vld_p4 <= 1'b0;
      x_p1 <= '0; x_p2 <= '0; x_p3 <= '0; x_p4 <= '0;
      y_p1 <= '0; y_p2 <= '0; y_p3 <= '0; y_p4 <= '0;
      d_p1 <= '0; d_p2 <= '0; d_p3 <= '0; d_p4 <= '0;
      armed_p1 <= '0; blend_p1 <= '0;
      for (int i = 0; i < NUM_SHAPES; i++) begin
        dx_p1[i] <= '0; dy_p1[i] <= '0; rx2_p1[i] <= '0; ry2_p1[i] <= '0;
        r2p_p1[i] <= '0; colour_p1[i] <= '0;
      end
    end else begin
      vld_p1 <= accept;
      vld_p2 <= vld_p1;
      vld_p3 <= vld_p2;
      vld_p4 <= vld_p3;
      // S1: distances and coherent per-slot parameter snapshot
      if (accept) begin
        x_p1 <= x; y_p1 <= y; d_p1 <= data_in;
        for (int i = 0; i < NUM_SHAPES; i++) begin
          dx_p1[i]     <= (x >= cx[i]) ? x - cx[i] : cx[i] - x;
          dy_p1[i]     <= (y >= cy[i]) ? y - cy[i] : cy[i] - y;
          rx2_p1[i]    <= rx2[i];
          ry2_p1[i]    <= ry2[i];
          r2p_p1[i]    <= r2p[i];
          colour_p1[i] <= colour[i];
          armed_p1[i]  <= ctrl[i][CTRL_EN] && (rx2[i] != '0) && (ry2[i] != '0);
          blend_p1[i]  <= ctrl[i][CTRL_BLEND];
        end
      end
      // S2..S4: pixel sideband follows the point tests
      if (vld_p1) begin x_p2 <= x_p1; y_p2 <= y_p1; d_p2 <= d_p1; end
      if (vld_p2) begin x_p3 <= x_p2; y_p3 <= y_p2; d_p3 <= d_p2; end
      if (vld_p3) begin x_p4 <= x_p3; y_p4 <= y_p3; d_p4 <= d_p3; end
    end
  end

  logic [NUM_SHAPES-1:0] inside_p4, blend_p4;
  logic [DATA_W-1:0]     colour_p4 [NUM_SHAPES];

  for (genvar g = 0; g < NUM_SHAPES; g++) begin : g_slot
    ellipse_point_test #(.X_W(X_W), .Y_W(Y_W), .DATA_W(DATA_W)) u_point_test (
      .clk       (clk),
      .rst_n     (rst_n),
      .vld_p1    (vld_p1),
      .dx_p1     (dx_p1[g]),
      .dy_p1     (dy_p1[g]),
      .rx2_p1    (rx2_p1[g]),
      .ry2_p1    (ry2_p1[g]),
      .r2p_p1    (r2p_p1[g]),
      .armed_p1  (armed_p1[g]),
      .blend_p1  (blend_p1[g]),
      .colour_p1 (colour_p1[g]),
      .inside_p4 (inside_p4[g]),
      .blend_p4  (blend_p4[g]),
      .colour_p4 (colour_p4[g])
    );
  end

  function automatic logic [DATA_W-1:0] blend_avg(input logic [DATA_W-1:0] c,
                                                  input logic [DATA_W-1:0] p);
    logic [DATA_W-1:0] r;
    logic [8:0]        s;
    r = '0;
    for (int b = 0; b < DATA_W / 8; b++) begin
      s = {1'b0, c[8*b +: 8]} + {1'b0, p[8*b +: 8]};
      r[8*b +: 8] = s[8:1];
    end
    return r;
  endfunction

  // Walk from highest to lowest index so the lowest inside slot is applied last.
  always_comb begin
    data_out = d_p4;
    for (int i = NUM_SHAPES - 1; i >= 0; i--) begin
      if (inside_p4[i])
        data_out = blend_p4[i] ? blend_avg(colour_p4[i], d_p4) : colour_p4[i];
    end
  end

  assign valid_out = vld_p4;
  assign x_out     = x_p4;
  assign y_out     = y_p4;

endmodule

// File: tb/tb_ellipse_renderer_multi.sv
// Directed bench for ellipse_renderer_multi: pass-through stream, slot geometry,
// priority, blending, ignored writes, radius hazard and mid-stream reset.
module tb_ellipse_renderer_multi;

  localparam int X_W = 11;
  localparam int Y_W = 12;
  localparam int DATA_W = 32;
  localparam int NUM_SHAPES = 4;

  logic              clk, rst_n, program_in, valid_in;
  logic [X_W-1:0]    x;
  logic [Y_W-1:0]    y;
  logic [DATA_W-1:0] data_in;
  logic              valid_out;
  logic [X_W-1:0]    x_out;
  logic [Y_W-1:0]    y_out;
  logic [DATA_W-1:0] data_out;

  int total = 0;
  int bad = 0;

  ellipse_renderer_multi #(.X_W(X_W), .Y_W(Y_W), .DATA_W(DATA_W), .NUM_SHAPES(NUM_SHAPES)) dut (
    .clk(clk), .rst_n(rst_n), .program_in(program_in), .valid_in(valid_in),
    .x(x), .y(y), .data_in(data_in),
    .valid_out(valid_out), .x_out(x_out), .y_out(y_out), .data_out(data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wr(input int slot, input int r, input logic [31:0] val);
    program_in = 1'b1;
    valid_in   = 1'b0;
    x          = X_W'(slot);
    y          = Y_W'(r);
    data_in    = val;
    step();
    program_in = 1'b0;
  endtask

  task automatic pix_chk(input string tag, input int px, input int py,
                         input logic [31:0] pd, input logic [31:0] exp);
    valid_in = 1'b1;
    x        = X_W'(px);
    y        = Y_W'(py);
    data_in  = pd;
    step();
    valid_in = 1'b0;
    idle(3);
    chk({tag, "_vld"}, valid_out, 1);
    chk(tag, data_out, exp);
  endtask

  bit          sv [8];
  bit          sp [8];
  logic [31:0] lastd;
  logic [10:0] lastx;
  logic [11:0] lasty;

  initial begin
    rst_n = 1'b0; program_in = 1'b0; valid_in = 1'b0;
    x = '0; y = '0; data_in = '0;
    idle(2);
    chk("rst_vld", valid_out, 0);
    chk("rst_data", data_out, 0);
    chk("rst_x", x_out, 0);
    chk("rst_y", y_out, 0);
    rst_n = 1'b1;
    step();

    // Pass-through stream with a natural bubble and an ignored program cycle.
    sv = '{1, 1, 1, 1, 1, 0, 1, 1};
    sp = '{0, 0, 0, 1, 0, 0, 0, 0};
    lastd = '0; lastx = '0; lasty = '0;
    for (int c = 0; c < 11; c++) begin
      int   o;
      logic expv;
      if (c < 8) begin
        valid_in   = sv[c];
        program_in = sp[c];
        if (sp[c]) begin
          x = 11'd7; y = 12'd4; data_in = 32'hDEADBEEF;
        end else begin
          x = 11'(c * 3 + 1); y = 12'(c * 5 + 2);
          data_in = 32'h1000_0000 + 32'(c) * 32'h0101;
        end
      end else begin
        valid_in = 1'b0; program_in = 1'b0;
      end
      step();
      if (c < 3) begin
        chk("stream_lead_vld", valid_out, 0);
      end else begin
        o = c - 3;
        expv = sv[o] && !sp[o];
        if (expv) begin
          lastd = 32'h1000_0000 + 32'(o) * 32'h0101;
          lastx = 11'(o * 3 + 1);
          lasty = 12'(o * 5 + 2);
        end
        chk("stream_vld", valid_out, expv);
        chk("stream_data", data_out, lastd);
        chk("stream_x", x_out, lastx);
        chk("stream_y", y_out, lasty);
      end
    end

    // Slot 0 geometry.
    wr(0, 0, 540); wr(0, 1, 1080); wr(0, 2, 270); wr(0, 3, 540);
    wr(0, 4, 32'hFF0000FF); wr(0, 5, 1);
    idle(3);
    pix_chk("centre", 540, 1080, 32'hFFFF0000, 32'hFF0000FF);
    chk("centre_x", x_out, 540);
    chk("centre_y", y_out, 1080);
    pix_chk("edge_x", 810, 1080, 32'hFFFF0000, 32'hFF0000FF);
    pix_chk("out_x", 811, 1080, 32'hFFFF0000, 32'hFFFF0000);
    pix_chk("edge_y", 540, 1620, 32'hFFFF0000, 32'hFF0000FF);
    pix_chk("out_y", 540, 1621, 32'hFFFF0000, 32'hFFFF0000);

    // Priority between overlapping slots.
    wr(1, 0, 540); wr(1, 1, 1080); wr(1, 2, 100); wr(1, 3, 100);
    wr(1, 4, 32'hFF00FF00); wr(1, 5, 1);
    idle(3);
    pix_chk("prio", 540, 1080, 32'hFFFF0000, 32'hFF0000FF);
    wr(0, 5, 0);
    pix_chk("prio_dis", 540, 1080, 32'hFFFF0000, 32'hFF00FF00);

    // Blend: bytes FF/FF, 00/FF, 00/00, FF/00 averaged and truncated.
    wr(0, 5, 3);
    pix_chk("blend", 540, 1080, 32'hFFFF0000, 32'hFF7F007F);
    pix_chk("blend_in", 700, 1080, 32'hFFFF0000, 32'hFF7F007F);

    // Out-of-range slot and register indices leave every slot untouched.
    wr(7, 4, 32'h12345678); wr(4, 5, 0); wr(4, 4, 0); wr(0, 6, 0); wr(7, 5, 0);
    pix_chk("bad_wr", 540, 1080, 32'hFFFF0000, 32'hFF7F007F);

    // Zero radius on slot 0, pixel entering three cycles after the write.
    wr(0, 2, 0);
    idle(2);
    pix_chk("rx0_pass", 700, 1080, 32'hFFFF0000, 32'hFFFF0000);
    pix_chk("rx0_slot1", 540, 1080, 32'hFFFF0000, 32'hFF00FF00);

    // Asynchronous reset in the middle of a stream.
    valid_in = 1'b1; x = 11'd540; y = 12'd1080; data_in = 32'hFFFF0000;
    idle(5);
    chk("pre_rst_vld", valid_out, 1);
    chk("pre_rst_data", data_out, 32'hFF00FF00);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_vld", valid_out, 0);
    chk("mid_rst_data", data_out, 0);
    chk("mid_rst_x", x_out, 0);
    step();
    rst_n = 1'b1;
    valid_in = 1'b0;
    step();
    chk("post_rst_idle", valid_out, 0);
    pix_chk("post_rst", 540, 1080, 32'hFFFF0000, 32'hFFFF0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
